// File: rtl/tcnt_macro.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tcnt_macro
//
// Parametrised synchronous counter / shift-register macrocell. A single cell
// covers hold, parallel load, modulo up/down count and shift-left. It exposes
// a terminal-count carry for synchronous ripple-enable cascading.
//
// Ports
//   c1   in   1      clock, rising edge active
//   r2   in   1      asynchronous reset, active-high, loads RST_VAL
//   m3   in   2      mode: 00 hold, 01 count, 10 load, 11 shift left
//   x4   in   WIDTH  parallel load data
//   x5   in   1      count/shift enable (cascade carry-in)
//   x6   in   1      count direction: 1 up, 0 down
//   x7   in   1      serial data in for shift mode
//   q7   out  WIDTH  register state
//   co8  out  1      terminal count / carry-out (count mode only)
//   so9  out  1      serial out, q7[WIDTH-1]
//   z10  out  1      high when q7 == 0
//
// Parameters
//   WIDTH    register width, 1..16
//   MODULUS  count modulus, 2..2**WIDTH; counting wraps within 0..MODULUS-1
//   RST_VAL  reset value; may be >= MODULUS
//   TPD_Q    clock/reset to q7 delay (ns), delay build only
//   TPD_C    input/state to co8/so9/z10 delay (ns), delay build only
//
// Build option
//   LIB1801_CELL_DELAY_EN  when defined, outputs carry modelled inertial
//                          delays (TPD_Q on q7, TPD_C on co8/so9/z10). When
//                          undefined all outputs are zero-delay. Cycle
//                          behaviour is the same in both builds.
// -----------------------------------------------------------------------------
module tcnt_macro #(
   parameter int               WIDTH   = 4,
   parameter int               MODULUS = 2**WIDTH,
   parameter logic [WIDTH-1:0] RST_VAL = '0,
   parameter real              TPD_Q   = 7.00,
   parameter real              TPD_C   = 5.25
) (
   input  logic             c1,
   input  logic             r2,
   input  logic [1:0]       m3,
   input  logic [WIDTH-1:0] x4,
   input  logic             x5,
   input  logic             x6,
   input  logic             x7,
   output logic [WIDTH-1:0] q7,
   output logic             co8,
   output logic             so9,
   output logic             z10
);

   typedef enum logic [1:0] {
      MODE_HOLD  = 2'b00,
      MODE_COUNT = 2'b01,
      MODE_LOAD  = 2'b10,
      MODE_SHIFT = 2'b11
   } mode_t;

   // ---------------------------------------------------------------------------
   // Elaboration-time parameter checks
   // ---------------------------------------------------------------------------
   if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
      $error("tcnt_macro: WIDTH=%0d outside 1..16", WIDTH);
   end

   if (MODULUS < 2 || MODULUS > 2**WIDTH) begin : g_bad_modulus
      $error("tcnt_macro: MODULUS=%0d outside 2..2**WIDTH", MODULUS);
   end

   if (TPD_Q < 0.0 || TPD_C < 0.0) begin : g_bad_delay
      $error("tcnt_macro: negative propagation delay");
   end

   // Highest in-range count value. Fits in WIDTH bits because MODULUS <= 2**WIDTH.
   localparam logic [WIDTH-1:0] LP_TOP = WIDTH'(MODULUS - 1);

   // ---------------------------------------------------------------------------
   // Internal signals
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] w_q_next;
   logic [WIDTH-1:0] w_shift;
   logic [WIDTH-1:0] w_up;
   logic [WIDTH-1:0] w_down;
   logic             w_r_top;
   logic             w_r_zero;
   logic             w_o_top;
   logic             w_o_zero;
   logic             w_co;
   logic             w_so;
   logic             w_z;
   mode_t            w_mode;

   assign w_mode = mode_t'(m3);

   // ---------------------------------------------------------------------------
   // Next-state datapath
   // ---------------------------------------------------------------------------
   // Anything at or above the top value wraps to zero on an up-count. This
   // also covers out-of-range values reached by load or RST_VAL.
   assign w_r_top  = (r_q >= LP_TOP);
   assign w_r_zero = (r_q == '0);

   assign w_up   = w_r_top  ? '0     : r_q + WIDTH'(1);
   // Out-of-range values simply decrement; only zero wraps to the top.
   assign w_down = w_r_zero ? LP_TOP : r_q - WIDTH'(1);

   // A one-bit register has nothing to shift; the serial input replaces it.
   if (WIDTH == 1) begin : g_shift_w1
      assign w_shift = x7;
   end else begin : g_shift_wn
      assign w_shift = {r_q[WIDTH-2:0], x7};
   end

   always_comb begin
      w_q_next = r_q;
      unique case (w_mode)
         MODE_HOLD:  w_q_next = r_q;
         MODE_LOAD:  w_q_next = x4;
         MODE_COUNT: begin
            if (x5) begin
               w_q_next = x6 ? w_up : w_down;
            end
         end
         MODE_SHIFT: begin
            if (x5) begin
               w_q_next = w_shift;
            end
         end
         default:    w_q_next = r_q;
      endcase
   end

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge c1 or posedge r2) begin
      if (r2) begin
         r_q <= RST_VAL;
      end else begin
         r_q <= w_q_next;
      end
   end

   // ---------------------------------------------------------------------------
   // Status outputs
   // ---------------------------------------------------------------------------
   // Decoded from the visible q7 rather than r_q so that in the delay build
   // the status outputs follow the delayed state, as the real cell would.
   assign w_o_top  = (q7 >= LP_TOP);
   assign w_o_zero = (q7 == '0);

   assign w_co = (w_mode == MODE_COUNT) && x5 && (x6 ? w_o_top : w_o_zero);
   assign w_so = q7[WIDTH-1];
   assign w_z  = w_o_zero;

`ifdef LIB1801_CELL_DELAY_EN
   // Continuous assignments with delay are inertial: glitches shorter than
   // the delay are swallowed, matching the other library cell models.
   assign #(TPD_Q) q7  = r_q;
   assign #(TPD_C) co8 = w_co;
   assign #(TPD_C) so9 = w_so;
   assign #(TPD_C) z10 = w_z;
`else
   assign q7  = r_q;
   assign co8 = w_co;
   assign so9 = w_so;
   assign z10 = w_z;
`endif

endmodule

// File: tb/tb_tcnt_macro.sv
`timescale 1ns/1ps
module tb_tcnt_macro;

   logic       c1 = 1'b0;
   logic       r2;
   logic [1:0] m3;
   logic [3:0] x4;
   logic       x5, x6, x7;
   logic [1:0] cas_m;
   logic       cas_en, cas_dir;

   logic [3:0] qa, qb, q0, q1;
   logic [0:0] qc;
   logic       coa, soa, za, cob, sob, zb, coc, soc, zc;
   logic       co0, so0, z0, co1, so1, z1;

   int  errors = 0;
   int  checks = 0;
   int  ma, mb, mc, ncas;
   bit  chk_en = 1'b0;

   always #5 c1 = ~c1;

   // A: modulo-10 counter with non-zero reset value
   tcnt_macro #(.WIDTH(4), .MODULUS(10), .RST_VAL(4'h5)) dut_a (
      .c1(c1), .r2(r2), .m3(m3), .x4(x4), .x5(x5), .x6(x6), .x7(x7),
      .q7(qa), .co8(coa), .so9(soa), .z10(za));

   // B: plain binary 4-bit, reset to all ones
   tcnt_macro #(.WIDTH(4), .RST_VAL(4'hF)) dut_b (
      .c1(c1), .r2(r2), .m3(m3), .x4(x4), .x5(x5), .x6(x6), .x7(x7),
      .q7(qb), .co8(cob), .so9(sob), .z10(zb));

   // C: single-bit cell
   tcnt_macro #(.WIDTH(1), .RST_VAL(1'b1)) dut_c (
      .c1(c1), .r2(r2), .m3(m3), .x4(x4[0]), .x5(x5), .x6(x6), .x7(x7),
      .q7(qc), .co8(coc), .so9(soc), .z10(zc));

   // Two-stage decimal cascade
   tcnt_macro #(.WIDTH(4), .MODULUS(10)) stage0 (
      .c1(c1), .r2(r2), .m3(cas_m), .x4(4'h0), .x5(cas_en), .x6(cas_dir), .x7(1'b0),
      .q7(q0), .co8(co0), .so9(so0), .z10(z0));

   tcnt_macro #(.WIDTH(4), .MODULUS(10)) stage1 (
      .c1(c1), .r2(r2), .m3(cas_m), .x4(4'h0), .x5(co0), .x6(cas_dir), .x7(1'b0),
      .q7(q1), .co8(co1), .so9(so1), .z10(z1));

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: value after one clock, from the mode rules
   function automatic int nxt(int q, int m, int w, logic [1:0] md, int d,
                              logic en, logic up, logic si);
      int r;
      r = q;
      if (md == 2'b10) r = d;
      else if (md == 2'b01 && en) begin
         if (up) r = (q >= m - 1) ? 0 : q + 1;
         else    r = (q == 0) ? m - 1 : q - 1;
      end else if (md == 2'b11 && en) begin
         r = (q * 2 + int'(si)) % (1 << w);
      end
      return r;
   endfunction

   function automatic logic co_exp(int q, int m, logic [1:0] md, logic en, logic up);
      return (md == 2'b01) && en && (up ? (q >= m - 1) : (q == 0));
   endfunction

   always @(posedge c1 or posedge r2) begin
      if (r2) begin
         ma = 5; mb = 15; mc = 1; ncas = 0;
      end else begin
         ma = nxt(ma, 10, 4, m3, int'(x4), x5, x6, x7);
         mb = nxt(mb, 16, 4, m3, int'(x4), x5, x6, x7);
         mc = nxt(mc, 2, 1, m3, int'(x4[0]), x5, x6, x7);
         if (cas_m == 2'b01 && cas_en)
            ncas = cas_dir ? (ncas + 1) % 100 : (ncas + 99) % 100;
      end
   end

   always @(negedge c1) begin
      if (chk_en) begin
         logic e0;
         check("a_q",  qa,  ma);
         check("a_co", coa, co_exp(ma, 10, m3, x5, x6));
         check("a_so", soa, (ma >> 3) & 1);
         check("a_z",  za,  ma == 0);
         check("b_q",  qb,  mb);
         check("b_co", cob, co_exp(mb, 16, m3, x5, x6));
         check("b_so", sob, (mb >> 3) & 1);
         check("b_z",  zb,  mb == 0);
         check("c_q",  qc,  mc);
         check("c_co", coc, co_exp(mc, 2, m3, x5, x6));
         check("c_so", soc, mc & 1);
         check("c_z",  zc,  mc == 0);
         e0 = co_exp(ncas % 10, 10, cas_m, cas_en, cas_dir);
         check("s0_q",  q0,  ncas % 10);
         check("s1_q",  q1,  ncas / 10);
         check("s0_co", co0, e0);
         check("s1_co", co1, co_exp(ncas / 10, 10, cas_m, e0, cas_dir));
         check("s1_z",  z1,  ncas / 10 == 0);
      end
   end

   task automatic step(input logic [1:0] m, input logic [3:0] d,
                       input logic en, input logic up, input logic si);
      m3 = m; x4 = d; x5 = en; x6 = up; x7 = si;
      @(posedge c1);
      #1;
   endtask

   initial begin
      int up_q[4]  = '{8, 9, 0, 1};
      int up_co[4] = '{0, 1, 0, 0};
      int dn_q[3]  = '{0, 9, 8};
      int dn_co[3] = '{1, 0, 0};
      int sh_q[3]  = '{3, 6, 13};
      int sh_so[3] = '{0, 0, 1};
      logic [2:0] sh_in = 3'b101;

      r2 = 1'b0; m3 = 2'b00; x4 = 4'h0; x5 = 1'b0; x6 = 1'b1; x7 = 1'b0;
      cas_m = 2'b00; cas_en = 1'b0; cas_dir = 1'b1;
      #1 r2 = 1'b1;
      #1;
      check("rst_qa", qa, 5);
      check("rst_za", za, 0);
      check("rst_qb", qb, 15);
      check("rst_qc", qc, 1);
      @(posedge c1);
      #1 r2 = 1'b0;
      chk_en = 1'b1;

      for (int i = 0; i < 3; i++) begin
         step(2'b00, 4'h0, 1'b1, 1'b1, 1'b0);
         check("hold_qa", qa, 5);
      end

      // Reset asserted and released between clock edges
      step(2'b10, 4'h3, 1'b0, 1'b1, 1'b0);
      check("load3_qa", qa, 3);
      m3 = 2'b00;
      #1 r2 = 1'b1;
      #1;
      check("midrst_qa", qa, 5);
      check("midrst_za", za, 0);
      #1 r2 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(2'b00, 4'h0, 1'b0, 1'b1, 1'b0);
         check("post_rst_qa", qa, 5);
      end

      step(2'b10, 4'h7, 1'b0, 1'b1, 1'b0);
      check("up_load", qa, 7);
      for (int i = 0; i < 4; i++) begin
         step(2'b01, 4'h0, 1'b1, 1'b1, 1'b0);
         check("up_q",  qa,  up_q[i]);
         check("up_co", coa, up_co[i]);
         check("up_z",  za,  up_q[i] == 0);
      end

      step(2'b10, 4'h1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(2'b01, 4'h0, 1'b1, 1'b0, 1'b0);
         check("dn_q",  qa,  dn_q[i]);
         check("dn_co", coa, dn_co[i]);
      end

      step(2'b10, 4'hC, 1'b0, 1'b1, 1'b0);
      check("oor_load", qa, 12);
      step(2'b01, 4'h0, 1'b1, 1'b1, 1'b0);
      check("oor_up", qa, 0);
      for (int i = 0; i < 2; i++) begin
         step(2'b01, 4'h0, 1'b0, 1'b1, 1'b0);
         check("en0_q",  qa,  0);
         check("en0_co", coa, 0);
      end

      step(2'b10, 4'h9, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(2'b11, 4'h0, 1'b1, 1'b1, sh_in[2-i]);
         check("sh_q",  qa,  sh_q[i]);
         check("sh_so", soa, sh_so[i]);
      end

      step(2'b10, 4'hF, 1'b0, 1'b1, 1'b0);
      step(2'b01, 4'h0, 1'b1, 1'b1, 1'b0);
      check("bin_wrap_up_b", qb, 0);
      check("bin_wrap_up_a", qa, 0);
      step(2'b01, 4'h0, 1'b1, 1'b0, 1'b0);
      check("bin_wrap_dn_b", qb, 15);
      check("bin_wrap_dn_a", qa, 9);

      // Cascade: 99 then 100 counts from 00
      cas_m = 2'b01; cas_en = 1'b1; cas_dir = 1'b1;
      for (int i = 0; i < 99; i++) step(2'b00, 4'h0, 1'b0, 1'b1, 1'b0);
      check("cas99_q1", q1, 9);
      check("cas99_q0", q0, 9);
      check("cas99_co1", co1, 1);
      step(2'b00, 4'h0, 1'b0, 1'b1, 1'b0);
      check("cas100_q1", q1, 0);
      check("cas100_q0", q0, 0);

      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 49) == 0) begin
            #1 r2 = 1'b1;
            #1 r2 = 1'b0;
         end
         cas_m   = 2'($urandom_range(0, 1));
         cas_en  = ($urandom_range(0, 3) != 0);
         cas_dir = 1'($urandom_range(0, 1));
         step(2'($urandom_range(0, 3)), 4'($urandom), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      @(negedge c1);
      #1;
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tcnt_macro.md
Name: tcnt_macro

Overview:
- Parametrised synchronous counter/shift-register macrocell for the 1801 gate-array cell library.
- It is the clocked successor to the RS/D-latch primitives: one cell replaces chains of latch cells plus gating in timer, prescaler and bit-serial paths.
- Supports hold, load, modulo up/down count and shift, with cascade carry and an optional modelled propagation delay.

Parameters:
- WIDTH, 4, register width in bits (1..16)
- MODULUS, 2**WIDTH, count modulus (2..2**WIDTH); counting wraps within 0..MODULUS-1
- RST_VAL, 0, value loaded into q7 on reset (WIDTH bits)
- TPD_Q, 7.00, clock-to-q7 delay in ns, used only with the delay feature
- TPD_C, 5.25, delay in ns from inputs/state to co8, z10 and so9, used only with the delay feature

Ports:
- c1  input  1  clock, rising edge active
- r2  input  1  reset, asynchronous, active-high
- m3  input  2  mode: 00 hold, 01 count, 10 load, 11 shift left
- x4  input  WIDTH  parallel load data
- x5  input  1  count/shift enable (cascade carry-in)
- x6  input  1  direction for count mode: 1 up, 0 down
- x7  input  1  serial data in for shift mode
- q7  output  WIDTH  register state
- co8  output  1  terminal count/carry-out
- so9  output  1  serial out, equal to q7[WIDTH-1]
- z10  output  1  high when q7 == 0

Behaviour:
- Reset: r2 high forces q7 = RST_VAL immediately, independent of c1, and holds it while r2 is high. co8, so9 and z10 follow from q7 and the inputs. Release of r2 takes effect at the next rising c1; no edge is lost or duplicated.
- State updates only on a rising c1 edge while r2 is low. There is one cycle of latency from inputs to q7.
- m3=00 hold: q7 is unchanged. x5 is ignored.
- m3=10 load: q7 <= x4 regardless of x5. Values >= MODULUS are loaded unmodified.
- m3=01 count, x5=1:
  - Up: q7 <= (q7 >= MODULUS-1) ? 0 : q7+1.
  - Down: q7 <= (q7 == 0) ? MODULUS-1 : q7-1. An out-of-range value decrements normally.
  - With x5=0, q7 holds.
- m3=11 shift, x5=1: q7 <= {q7[WIDTH-2:0], x7}. With WIDTH=1, q7 <= x7. With x5=0, q7 holds.
- co8 (combinational): m3==01 & x5 & (x6 ? q7>=MODULUS-1 : q7==0). It is 0 in all other modes. It is intended to drive x5 of the next cascade stage, giving synchronous ripple-enable cascading.
- so9 = q7[WIDTH-1]. z10 = (q7 == 0).
- Simultaneous events: asynchronous reset dominates any clock edge. Mode is sampled only at the clock edge.
- MODULUS == 2**WIDTH gives plain binary wrap (all-ones to 0 and 0 to all-ones). Arithmetic is WIDTH bits with no sign.
- Parameter checks (elaboration): WIDTH out of range or MODULUS out of range triggers $error. RST_VAL >= MODULUS is legal; the first up-count from that value wraps to 0.

Optional Feature:
- Macro: LIB1801_CELL_DELAY_EN.
- Defined: q7 updates TPD_Q ns after the c1 edge or r2 assertion. co8, so9 and z10 settle TPD_C ns after their last input change, with inertial behaviour, consistent with the other library cells.
- Undefined: all outputs are zero-delay, for fast RTL regression. Cycle behaviour is identical in both builds.

Test Plan:
- Reset: WIDTH=4, RST_VAL=4'h5. Assert r2 mid-cycle with c1 idle -> q7 = 5 immediately, z10=0. Release r2, then hold for 3 clocks -> q7 stays 5.
- Modulo up: MODULUS=10, load 7, count up with x5=1 for 4 clocks -> q7 = 8,9,0,1. co8=1 only while q7=9. z10=1 at 0.
- Modulo down: MODULUS=10, load 1, count down for 3 clocks -> q7 = 0,9,8. co8=1 only while q7=0.
- Out-of-range and enable: MODULUS=10, load 4'hC, count up -> q7 = 0. Then set x5=0 for 2 clocks -> q7 holds 0 and co8=0.
- Shift: WIDTH=4, load 4'b1001, shift with x7 = 1,0,1 -> q7 = 0011, 0110, 1101. so9 = 0,0,1.
- Cascade: two instances with stage0.co8 driving stage1.x5, MODULUS=10, up from 00. After 100 clocks -> {q1,q0} = 0,0. At 99 -> 9,9. Stage1 increments only on stage0 wrap. With LIB1801_CELL_DELAY_EN defined, q7 changes TPD_Q ns after c1.
